// File: rtl/wb_arb_pkg.sv
// Shared widths and the write-port request type for the register-file write arbiter.
// Used by wb_fifo2 and wb_port_arbiter.
package wb_arb_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned COUNT_W    = 2;

    typedef struct packed {
        logic [DATA_W-1:0] Dw;
        logic [ADDR_W-1:0] Aw;
    } wb_req_t;

    function automatic wb_req_t make_req(input logic [DATA_W-1:0] dw,
                                         input logic [ADDR_W-1:0] aw);
        wb_req_t r;
        r.Dw = dw;
        r.Aw = aw;
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry first-in first-out buffer for MDU results; slot 0 is always the head.
// A push is dropped when full, even if a pop happens in the same cycle.
module wb_fifo2
    import wb_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  wb_req_t            push_data_i,
    input  logic               pop_i,
    output wb_req_t            head_o,
    output logic [COUNT_W-1:0] count_o
);

    wb_req_t            slot0_q;
    wb_req_t            slot0_d;
    wb_req_t            slot1_q;
    wb_req_t            slot1_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] count_after_pop;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q < COUNT_W'(FIFO_DEPTH));

    always_comb begin
        slot0_d         = slot0_q;
        slot1_d         = slot1_q;
        count_after_pop = count_q;
        if (do_pop) begin
            slot0_d         = slot1_q;
            count_after_pop = count_q - COUNT_W'(1);
        end
        count_d = count_after_pop;
        if (do_push) begin
            // Land behind whatever survives the pop so order is preserved.
            if (count_after_pop == '0) begin
                slot0_d = push_data_i;
            end else begin
                slot1_d = push_data_i;
            end
            count_d = count_after_pop + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline (P) versus buffered MDU results (M).
// Optional starvation guard is compiled in by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pipeDw,
    input  logic [ADDR_W-1:0] pipeAw,
    input  logic              pipeRegWr,
    input  logic [DATA_W-1:0] mduDw,
    input  logic [ADDR_W-1:0] mduAw,
    input  logic              mduValid,
    output logic              mduReady,
    output logic              stallPipe,
    output logic [DATA_W-1:0] DwOut,
    output logic [ADDR_W-1:0] AwOut,
    output logic              RegWrOut
);

    logic [COUNT_W-1:0] fifo_count;
    wb_req_t            fifo_head;
    wb_req_t            mdu_req;
    wb_req_t            win_req;
    logic               fifo_empty;
    logic               fifo_push;
    logic               grant_m;
    logic               grant_p;

    logic [DATA_W-1:0]  dw_q;
    logic [DATA_W-1:0]  dw_d;
    logic [ADDR_W-1:0]  aw_q;
    logic [ADDR_W-1:0]  aw_d;
    logic               regwr_q;
    logic               regwr_d;

    assign fifo_empty = (fifo_count == '0);
    assign mduReady   = !reset && (fifo_count < COUNT_W'(FIFO_DEPTH));
    // Results for $0 are accepted but never buffered.
    assign fifo_push  = mduValid && mduReady && (mduAw != '0);
    assign mdu_req    = make_req(mduDw, mduAw);

    wb_fifo2 u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (mdu_req),
        .pop_i       (grant_m),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned        STARVE_W = 4;
    localparam logic [STARVE_W-1:0] LimitC   = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    assign stallPipe = !fifo_empty && (starve_q == LimitC);

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant_m) begin
            starve_d = '0;
        end else if (starve_q != LimitC) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign stallPipe = 1'b0;
`endif

    always_comb begin
        grant_m = 1'b0;
        grant_p = 1'b0;
        if (stallPipe) begin
            grant_m = 1'b1;
        end else if (pipeRegWr) begin
            grant_p = 1'b1;
        end else if (!fifo_empty) begin
            grant_m = 1'b1;
        end
    end

    assign win_req = grant_p ? make_req(pipeDw, pipeAw) : fifo_head;

    always_comb begin
        dw_d    = dw_q;
        aw_d    = aw_q;
        regwr_d = grant_m || grant_p;
        if (regwr_d) begin
            dw_d = win_req.Dw;
            aw_d = win_req.Aw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dw_q    <= '0;
            aw_q    <= '0;
            regwr_q <= 1'b0;
        end else begin
            dw_q    <= dw_d;
            aw_q    <= aw_d;
            regwr_q <= regwr_d;
        end
    end

    assign DwOut    = dw_q;
    assign AwOut    = aw_q;
    assign RegWrOut = regwr_q;

    a_limit_legal: assert property (@(posedge clk) disable iff (reset)
        (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

    a_stall_has_head: assert property (@(posedge clk) disable iff (reset)
        stallPipe |-> !fifo_empty);

    a_one_grant: assert property (@(posedge clk) disable iff (reset)
        !(grant_m && grant_p));

endmodule
